// File: rtl/vdp_sprite_y_scan_db.sv
// Double-buffered sprite Y-test scan: walks the attribute table each line.
// Optional VDP_SPRITE_NOLIMIT_EN adds reg_sp_nolimit (mode2 limit in all modes).
module vdp_sprite_y_scan_db #(
  parameter int SP_NUM = 32,
  parameter int SP_LINE_MAX = 8,
  parameter int SP_LINE_MAX_M1 = 4,
  parameter logic [8:0] SCAN_START = 9'd0,
  localparam int RW = $clog2(SP_LINE_MAX),
  localparam int CW = $clog2(SP_LINE_MAX + 1)
) (
  input  logic          clk21m,
  input  logic          reset,
  input  logic [1:0]    dot_state,
  input  logic [2:0]    eight_dot_state,
  input  logic          sp_y_test_state,
  input  logic [8:0]    dot_counter_x,
  input  logic [8:0]    current_y,
  input  logic          vdp_s0_reset_timing,
  output logic          vdp_s0_sp_overmapped,
  output logic [4:0]    vdp_s0_sp_overmapped_num,
  input  logic          reg_r1_sp_size,
  input  logic          reg_r1_sp_zoom,
  input  logic          sp_mode2,
`ifdef VDP_SPRITE_NOLIMIT_EN
  input  logic          reg_sp_nolimit,
`endif
  input  logic [9:0]    attribute_table_address,
  input  logic [RW-1:0] current_render_sp,
  output logic [4:0]    render_sp,
  output logic [CW-1:0] render_sp_num,
  input  logic [7:0]    vram_q,
  output logic [16:0]   vram_a
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, state_n;

  logic [4:0]    bank [2][SP_LINE_MAX];
  logic          wr_bank;
  logic [CW-1:0] wr_cnt;
  logic [4:0]    idx;

  logic          line_start;
  logic [7:0]    diff;
  logic [5:0]    h;
  logic          visible;
  logic          term;
  logic [CW-1:0] limit;
  logic          full;
  logic          last;
  logic          fetch;
  logic          eval;
  logic          store;
  logic          ovr;
  logic          set_ovr;
  logic          track;
  logic          stop;
  logic          unused_ok;

  assign unused_ok = ^{eight_dot_state, current_y[8]};

  assign line_start = (dot_counter_x == SCAN_START) && (dot_state == 2'b00);
  assign diff = current_y[7:0] - vram_q;
  assign h = 6'd8 << ({1'b0, reg_r1_sp_size} + {1'b0, reg_r1_sp_zoom});
  assign visible = diff < {2'b00, h};
  assign term = sp_mode2 ? (vram_q == 8'd216) : (vram_q == 8'd208);

`ifdef VDP_SPRITE_NOLIMIT_EN
  assign limit = (sp_mode2 || reg_sp_nolimit) ?
                 CW'(SP_LINE_MAX) : CW'(SP_LINE_MAX_M1);
`else
  assign limit = sp_mode2 ? CW'(SP_LINE_MAX) : CW'(SP_LINE_MAX_M1);
`endif

  assign full = wr_cnt >= limit;
  assign last = idx == 5'(SP_NUM - 1);

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (line_start && sp_y_test_state) state_n = SCAN;
      end
      SCAN: begin
        if (line_start)
          state_n = sp_y_test_state ? SCAN : IDLE;
        else if (!sp_y_test_state || stop)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fetch = 1'b0;
    eval = 1'b0;
    if (line_start)
      fetch = sp_y_test_state;
    else if (state == SCAN && sp_y_test_state) begin
      fetch = dot_state == 2'b00;
      eval = dot_state == 2'b10;
    end
    store = eval && !term && visible && !full;
    ovr = eval && !term && visible && full;
    set_ovr = ovr && !vdp_s0_sp_overmapped;
    track = eval && !ovr && !vdp_s0_sp_overmapped;
`ifdef VDP_SPRITE_NOLIMIT_EN
    // Overmap only flags; scanning runs on to the last entry.
    stop = eval && (term || last);
`else
    stop = eval && (term || ovr || last);
`endif
  end

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < SP_LINE_MAX; s++)
          bank[b][s] <= 5'd0;
      wr_bank <= 1'b0;
      wr_cnt <= '0;
      render_sp_num <= '0;
      idx <= 5'd0;
      vram_a <= 17'd0;
    end else begin
      if (line_start) begin
        wr_bank <= ~wr_bank;
        render_sp_num <= wr_cnt;
        wr_cnt <= '0;
        idx <= 5'd0;
      end else if (eval) begin
        idx <= idx + 5'd1;
      end
      if (store) begin
        bank[wr_bank][wr_cnt[RW-1:0]] <= idx;
        wr_cnt <= wr_cnt + CW'(1);
      end
      if (fetch)
        vram_a <= {attribute_table_address,
                   line_start ? 5'd0 : idx, 2'b00};
    end
  end

  // An overmap set beats a coincident S#0 read strobe.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      vdp_s0_sp_overmapped <= 1'b0;
      vdp_s0_sp_overmapped_num <= 5'd0;
    end else if (set_ovr) begin
      vdp_s0_sp_overmapped <= 1'b1;
      vdp_s0_sp_overmapped_num <= idx;
    end else if (vdp_s0_reset_timing) begin
      vdp_s0_sp_overmapped <= 1'b0;
      vdp_s0_sp_overmapped_num <= 5'd0;
    end else if (track) begin
      vdp_s0_sp_overmapped_num <= idx;
    end
  end

  assign render_sp = bank[~wr_bank][current_render_sp];

endmodule

// File: tb/tb_vdp_sprite_y_scan_db.sv
// Bench for vdp_sprite_y_scan_db: vector table plus corner sequences.
// Expected render counts go through a queue and are checked after the swap.
module tb_vdp_sprite_y_scan_db;

  logic       clk21m = 1'b0;
  logic       reset;
  logic [1:0] dot_state;
  logic [2:0] eight_dot_state;
  logic       sp_y_test_state;
  logic [8:0] dot_counter_x;
  logic [8:0] current_y;
  logic       vdp_s0_reset_timing;
  logic       vdp_s0_sp_overmapped;
  logic [4:0] vdp_s0_sp_overmapped_num;
  logic       reg_r1_sp_size;
  logic       reg_r1_sp_zoom;
  logic       sp_mode2;
  logic [9:0] attribute_table_address;
  logic [2:0] current_render_sp;
  logic [4:0] render_sp;
  logic [3:0] render_sp_num;
  logic [7:0] vram_q;
  logic [16:0] vram_a;
`ifdef VDP_SPRITE_NOLIMIT_EN
  logic       reg_sp_nolimit = 1'b0;
`endif

  vdp_sprite_y_scan_db dut (
    .clk21m(clk21m),
    .reset(reset),
    .dot_state(dot_state),
    .eight_dot_state(eight_dot_state),
    .sp_y_test_state(sp_y_test_state),
    .dot_counter_x(dot_counter_x),
    .current_y(current_y),
    .vdp_s0_reset_timing(vdp_s0_reset_timing),
    .vdp_s0_sp_overmapped(vdp_s0_sp_overmapped),
    .vdp_s0_sp_overmapped_num(vdp_s0_sp_overmapped_num),
    .reg_r1_sp_size(reg_r1_sp_size),
    .reg_r1_sp_zoom(reg_r1_sp_zoom),
    .sp_mode2(sp_mode2),
`ifdef VDP_SPRITE_NOLIMIT_EN
    .reg_sp_nolimit(reg_sp_nolimit),
`endif
    .attribute_table_address(attribute_table_address),
    .current_render_sp(current_render_sp),
    .render_sp(render_sp),
    .render_sp_num(render_sp_num),
    .vram_q(vram_q),
    .vram_a(vram_a)
  );

  always #5 clk21m = ~clk21m;

  logic [7:0] ymem [32];
  assign vram_q = ymem[vram_a[6:2]];

  typedef struct {
    bit m2; bit sz; bit zm;
    int cy; int yv;
    int cnt; bit flg; int num;
  } vec_t;

  vec_t vt[13];
  int exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit scan_en = 1'b1;
  int abort_x = 1000;
  int s0_x = -1;
  logic [16:0] a_hold;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic dot(input int x);
    for (int p = 0; p < 4; p++) begin
      dot_state = (p == 0) ? 2'b00 : (p == 1) ? 2'b01 :
                  (p == 2) ? 2'b11 : 2'b10;
      eight_dot_state = 3'(x);
      dot_counter_x = 9'(x);
      sp_y_test_state = scan_en && (x < abort_x);
      vdp_s0_reset_timing = (x == s0_x) && (p == 3);
      @(posedge clk21m); #1;
    end
    vdp_s0_reset_timing = 1'b0;
  endtask

  task automatic run_line(input int n);
    for (int x = 0; x < n; x++) dot(x);
  endtask

  task automatic swap_line();
    bit keep;
    keep = scan_en;
    scan_en = 1'b0;
    dot(0);
    scan_en = keep;
  endtask

  task automatic clear_flag();
    dot_counter_x = 9'd100;
    dot_state = 2'b01;
    vdp_s0_reset_timing = 1'b1;
    @(posedge clk21m); #1;
    vdp_s0_reset_timing = 1'b0;
    chk("s0_clear_flag", int'(vdp_s0_sp_overmapped), 0);
    chk("s0_clear_num", int'(vdp_s0_sp_overmapped_num), 0);
  endtask

  task automatic fill(input int yv);
    for (int k = 0; k < 32; k++) ymem[k] = 8'(yv);
  endtask

  // Pops the expected count and checks the now-visible read bank.
  task automatic check_bank(input string name);
    int c;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      c = exp_q.pop_front();
      chk({name, "_num"}, int'(render_sp_num), c);
      for (int k = 0; k < c; k++) begin
        current_render_sp = 3'(k);
        #1;
        chk({name, "_sp"}, int'(render_sp), k);
      end
    end
  endtask

  initial begin
    vt[0]  = '{1, 0, 0, 10, 5, 8, 1, 8};
    vt[1]  = '{0, 0, 0, 210, 208, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 220, 216, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 220, 216, 4, 1, 4};
    vt[4]  = '{1, 1, 1, 131, 100, 8, 1, 8};
    vt[5]  = '{1, 1, 1, 132, 100, 0, 0, 31};
    vt[6]  = '{1, 1, 1, 5, 250, 8, 1, 8};
    vt[7]  = '{1, 0, 0, 20, 5, 0, 0, 31};
    vt[8]  = '{1, 1, 0, 20, 5, 8, 1, 8};
    vt[9]  = '{1, 0, 1, 20, 5, 8, 1, 8};
    vt[10] = '{1, 0, 0, 210, 208, 8, 1, 8};
    vt[11] = '{0, 0, 0, 10, 50, 0, 0, 31};
    vt[12] = '{0, 0, 0, 12, 5, 4, 1, 4};

    reset = 1'b1;
    dot_state = 2'b01;
    eight_dot_state = 3'd0;
    sp_y_test_state = 1'b0;
    dot_counter_x = 9'd100;
    current_y = 9'd0;
    vdp_s0_reset_timing = 1'b0;
    reg_r1_sp_size = 1'b0;
    reg_r1_sp_zoom = 1'b0;
    sp_mode2 = 1'b0;
    attribute_table_address = 10'h2a5;
    current_render_sp = 3'd0;
    fill(0);
    repeat (3) @(posedge clk21m);
    #1 reset = 1'b0;
    chk("rst_flag", int'(vdp_s0_sp_overmapped), 0);
    chk("rst_num", int'(vdp_s0_sp_overmapped_num), 0);
    chk("rst_render_num", int'(render_sp_num), 0);
    chk("rst_render_sp", int'(render_sp), 0);
    chk("rst_vram_a", int'(vram_a), 0);

    for (int i = 0; i < 13; i++) begin
      clear_flag();
      fill(vt[i].yv);
      sp_mode2 = vt[i].m2;
      reg_r1_sp_size = vt[i].sz;
      reg_r1_sp_zoom = vt[i].zm;
      current_y = 9'(vt[i].cy);
      run_line(34);
      exp_q.push_back(vt[i].cnt);
      chk("vec_flag", int'(vdp_s0_sp_overmapped), int'(vt[i].flg));
      chk("vec_num", int'(vdp_s0_sp_overmapped_num), vt[i].num);
      chk("vec_vram_a", int'(vram_a),
          int'({10'h2a5, 5'(vt[i].num), 2'b00}));
      swap_line();
      check_bank("vec");
    end

    // Overmap set and S#0 strobe in the same clock: set wins.
    clear_flag();
    fill(5);
    sp_mode2 = 1'b1;
    reg_r1_sp_size = 1'b0;
    reg_r1_sp_zoom = 1'b0;
    current_y = 9'd10;
    s0_x = 8;
    run_line(34);
    s0_x = -1;
    chk("coinc_flag", int'(vdp_s0_sp_overmapped), 1);
    chk("coinc_num", int'(vdp_s0_sp_overmapped_num), 8);
    clear_flag();

    // Scan enable dropped after three visible entries.
    abort_x = 3;
    run_line(34);
    abort_x = 1000;
    exp_q.push_back(3);
    chk("abort_flag", int'(vdp_s0_sp_overmapped), 0);
    chk("abort_num", int'(vdp_s0_sp_overmapped_num), 2);
    chk("abort_vram_a", int'(vram_a), int'({10'h2a5, 5'd2, 2'b00}));
    swap_line();
    check_bank("abort");

    // Scan disabled at line start: no fetch, empty bank.
    a_hold = vram_a;
    attribute_table_address = 10'h13c;
    scan_en = 1'b0;
    run_line(34);
    scan_en = 1'b1;
    exp_q.push_back(0);
    chk("off_vram_a", int'(vram_a), int'(a_hold));
    swap_line();
    check_bank("off");

    // Short line: next line start truncates after five entries.
    attribute_table_address = 10'h2a5;
    run_line(5);
    exp_q.push_back(5);
    chk("short_num", int'(vdp_s0_sp_overmapped_num), 4);
    swap_line();
    check_bank("short");

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vdp_sprite_y_scan_db.md
Name: vdp_sprite_y_scan_db

Overview:
Parametrised, double-buffered successor to the VDP sprite Y-test stage.
- During each line it walks the sprite attribute table one entry per dot and Y-tests every entry against current_y.
- It records up to a mode-dependent limit of visible sprite numbers into a write bank. At the next line start that bank becomes the read bank for the sprite renderer.
- It maintains the S#0 overmap flag and number.
- Sits between VRAM arbiter (attribute Y reads) and the sprite pattern/render stage.

Parameters:
SP_NUM, 32, attribute entries scanned per line (power of 2, ≤32)
SP_LINE_MAX, 8, max sprites per line in sprite mode 2 (≤16)
SP_LINE_MAX_M1, 4, max sprites per line in sprite mode 1 (≤SP_LINE_MAX)
SCAN_START, 9'd0, dot_counter_x value at which a line scan starts

Ports:
clk21m  in  1  21.48 MHz clock
reset  in  1  asynchronous, active-high
dot_state  in  2  dot phase, sequence 00→01→11→10
eight_dot_state  in  3  dot index within 8-dot slot (informational, unused for timing)
sp_y_test_state  in  1  scan enable
dot_counter_x  in  9  horizontal dot counter
current_y  in  9  line being prepared (low 8 bits used)
vdp_s0_reset_timing  in  1  S#0 read strobe, clears overmap flag
vdp_s0_sp_overmapped  out  1  5th/9th-sprite flag
vdp_s0_sp_overmapped_num  out  5  overmap / last-checked sprite number
reg_r1_sp_size  in  1  0=8px, 1=16px
reg_r1_sp_zoom  in  1  1=doubled
sp_mode2  in  1  sprite mode 2 select
attribute_table_address  in  10  attribute table base, A16..A7
current_render_sp  in  clog2(SP_LINE_MAX)  read-bank slot index
render_sp  out  5  sprite number at current_render_sp
render_sp_num  out  clog2(SP_LINE_MAX+1)  valid entries in read bank
vram_q  in  8  VRAM read data (Y byte)
vram_a  out  17  VRAM address

Behaviour:
- Reset: all outputs 0; both bank counts 0; scan idle; write bank = 0.
- Line start: dot_counter_x==SCAN_START and dot_state==00.
  - Swap banks.
  - render_sp_num takes the finished count.
  - Clear the write count and entry index.
  - Scan becomes active iff sp_y_test_state=1; otherwise the write bank stays empty (count 0).
- Per entry (one dot = 4 clocks):
  - dot_state 00: register vram_a = {attribute_table_address, idx[4:0], 2'b00}. vram_a holds between reads.
  - dot_state 10: sample vram_q and evaluate; then idx+1.
- Terminator: Y==208 (mode1) or Y==216 (mode2) ends the scan. The entry is not stored; overmapped_num = idx if the flag is clear.
- Visible test:
  - diff = current_y[7:0] − Y (mod 256).
  - h = 8 << size << zoom (8/16/32).
  - Visible iff diff < h.
- Storing a visible entry:
  - limit = sp_mode2 ? SP_LINE_MAX : SP_LINE_MAX_M1.
  - If count < limit, store idx at write slot count, then count+1.
  - If count == limit, set overmapped=1 and overmapped_num=idx, then end the scan. This applies only if the flag is clear; the scan ends either way.
- Non-overmap progress: while the flag is clear, overmapped_num tracks each examined idx, so it reads the last entry checked at scan end.
- Scan end: after idx==SP_NUM−1 is evaluated, or on a terminator or overmap. No further vram_a updates until the next line start.
- sp_y_test_state falling mid-scan: abort immediately; entries stored so far remain valid.
- S#0 clear: vdp_s0_reset_timing clears the flag and num.
  - If it coincides with an overmap set in the same clock, the set wins.
  - Otherwise the clear applies.
- Read side: render_sp = read_bank[current_render_sp], combinational from registers. Slots ≥ render_sp_num are don't-care.
- Line start during an active scan (short line): the scan is truncated and the partial count is swapped in.

Optional Feature:
Macro VDP_SPRITE_NOLIMIT_EN.
- Defined: extra input port reg_sp_nolimit (1 bit). When 1, limit = SP_LINE_MAX in both modes.
- Defined, overmap behaviour: the overmap flag still sets on the (SP_LINE_MAX+1)th sprite, but scanning continues to idx SP_NUM−1, storing nothing further.
- Not defined: port absent; limits as above; scan stops at overmap.

Test Plan:
1. Mode2, current_y=10, Y of entries 0..31 all =5, size=0 zoom=0 → entries 0..7 stored; overmapped=1, num=8; next line render_sp_num=8, render_sp[3]=3.
2. Mode1, vram_q=208 constant, current_y=210 → scan ends at idx 0, count 0, flag 0, num=0; vram_a = {base,5'd0,2'b00} only.
3. Mode2, vram_q=216, current_y=220 → same as 2 (terminator 216); then mode1 with Y=216, current_y=220 → not visible (diff=4? no: 4<8 visible), so entries 0..3 stored, flag set, num=4.
4. Size=1 zoom=1, Y=100: current_y=131 → visible; current_y=132 → not visible; wrap check Y=250, current_y=5 → diff=11 <32 visible.
5. Overmap and vdp_s0_reset_timing asserted in the same clock → flag=1; strobe one clock later → flag=0, num=0.
6. sp_y_test_state dropped after 3 entries (all visible) → next line render_sp_num=3; with it low at line start → render_sp_num=0 and vram_a unchanged.
